// File: rtl/blackjack_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | blackjack_game_ctrl: blackjack engine with LFSR/external shoe, ace-aware   |
// | scoring and automatic dealer play.    Revision: 1.0                        |
// +----------------------------------------------------------------------------+
module blackjack_game_ctrl #(
  parameter int          MAX_CARDS    = 9,
  parameter int          DEALER_STAND = 17,
  parameter int          EXT_DECK     = 0,
  parameter logic [15:0] SEED         = 16'hACE1,
  localparam int         CW           = $clog2(MAX_CARDS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_game,
  input  logic                   hit,
  input  logic                   stand,
  input  logic [3:0]             ext_rank,
  input  logic [1:0]             ext_suit,
  output logic                   card_take,
  output logic [4*MAX_CARDS-1:0] player_ranks,
  output logic [2*MAX_CARDS-1:0] player_suits,
  output logic [4*MAX_CARDS-1:0] dealer_ranks,
  output logic [2*MAX_CARDS-1:0] dealer_suits,
  output logic [CW-1:0]          player_count,
  output logic [CW-1:0]          dealer_count,
  output logic [5:0]             player_score,
  output logic [5:0]             dealer_score,
  output logic                   dealer_hidden,
  output logic [2:0]             phase,
  output logic [1:0]             outcome
);

  localparam logic [CW-1:0] c_max   = CW'(MAX_CARDS);
  localparam logic [5:0]    c_stand = 6'(DEALER_STAND);
  localparam logic [5:0]    c_bj    = 6'd21;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DEAL   = 3'd1,
    S_PLAYER = 3'd2,
    S_DEALER = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t                 r_state;
  logic [1:0]             r_k;
  logic [15:0]            r_lfsr;
  logic                   r_new_game_q;
  logic                   r_hit_q;
  logic                   r_stand_q;
  logic                   r_armed;
  logic [1:0]             r_outcome;
  logic [5:0]             r_p_hard;
  logic [5:0]             r_d_hard;
  logic                   r_p_ace;
  logic                   r_d_ace;
  logic [CW-1:0]          r_p_count;
  logic [CW-1:0]          r_d_count;
  logic [4*MAX_CARDS-1:0] r_p_ranks;
  logic [2*MAX_CARDS-1:0] r_p_suits;
  logic [4*MAX_CARDS-1:0] r_d_ranks;
  logic [2*MAX_CARDS-1:0] r_d_suits;

  logic          w_new_game_rise;
  logic          w_hit_rise;
  logic          w_stand_rise;
  logic          w_start;
  logic          w_fb;
  logic [3:0]    w_lfsr_r;
  logic [3:0]    w_lfsr_rank;
  logic [3:0]    w_rank;
  logic [1:0]    w_suit;
  logic [5:0]    w_pts;
  logic          w_is_ace;
  logic          w_take_p;
  logic          w_take_d;
  logic          w_d_draw;
  logic [5:0]    w_p_hard_nxt;
  logic [5:0]    w_d_hard_nxt;
  logic          w_p_ace_nxt;
  logic          w_d_ace_nxt;
  logic [5:0]    w_p_score;
  logic [5:0]    w_d_score;
  logic [5:0]    w_p_score_nxt;
  logic [CW-1:0] w_p_count_inc;
  logic [CW-1:0] w_d_count_inc;

  function automatic logic [5:0] score_of(input logic [5:0] hard, input logic ace);
    score_of = (ace && (hard <= 6'd11)) ? hard + 6'd10 : hard;
  endfunction

  function automatic logic [1:0] judge(input logic [5:0] p, input logic [5:0] d);
    if (p > c_bj)      judge = 2'd2;
    else if (d > c_bj) judge = 2'd1;
    else if (p > d)    judge = 2'd1;
    else if (d > p)    judge = 2'd2;
    else               judge = 2'd3;
  endfunction

  // r_armed blocks a button already held while rst releases from counting as a press.
  assign w_new_game_rise = new_game & ~r_new_game_q & r_armed;
  assign w_hit_rise      = hit      & ~r_hit_q      & r_armed;
  assign w_stand_rise    = stand    & ~r_stand_q    & r_armed;
  assign w_start         = w_new_game_rise & ((r_state == S_IDLE) || (r_state == S_RESULT));

  assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lfsr_r    = r_lfsr[3:0];
  assign w_lfsr_rank = ((w_lfsr_r >= 4'd13) ? (w_lfsr_r - 4'd13) : w_lfsr_r) + 4'd1;
  assign w_rank      = (EXT_DECK != 0) ? ext_rank : w_lfsr_rank;
  assign w_suit      = (EXT_DECK != 0) ? ext_suit : r_lfsr[5:4];

  assign w_is_ace = (w_rank == 4'd1);
  assign w_pts    = (w_rank >= 4'd11) ? 6'd10 : {2'b00, w_rank};

  assign w_p_hard_nxt  = r_p_hard + w_pts;
  assign w_d_hard_nxt  = r_d_hard + w_pts;
  assign w_p_ace_nxt   = r_p_ace | w_is_ace;
  assign w_d_ace_nxt   = r_d_ace | w_is_ace;
  assign w_p_score     = score_of(r_p_hard, r_p_ace);
  assign w_d_score     = score_of(r_d_hard, r_d_ace);
  assign w_p_score_nxt = score_of(w_p_hard_nxt, w_p_ace_nxt);
  assign w_p_count_inc = r_p_count + 1'b1;
  assign w_d_count_inc = r_d_count + 1'b1;

  assign w_d_draw = (w_d_score < c_stand) && (r_d_count < c_max);

  always_comb begin
    w_take_p = 1'b0;
    w_take_d = 1'b0;
    case (r_state)
      S_DEAL: begin
        w_take_p = ~r_k[0] & (r_p_count < c_max);
        w_take_d =  r_k[0] & (r_d_count < c_max);
      end
      S_PLAYER: w_take_p = w_hit_rise & ~w_stand_rise & (r_p_count < c_max);
      S_DEALER: w_take_d = w_d_draw;
      default: ;
    endcase
    if (rst) begin
      w_take_p = 1'b0;
      w_take_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_k          <= 2'd0;
      r_lfsr       <= SEED;
      r_new_game_q <= 1'b0;
      r_hit_q      <= 1'b0;
      r_stand_q    <= 1'b0;
      r_armed      <= 1'b0;
      r_outcome    <= 2'd0;
      r_p_hard     <= 6'd0;
      r_d_hard     <= 6'd0;
      r_p_ace      <= 1'b0;
      r_d_ace      <= 1'b0;
      r_p_count    <= '0;
      r_d_count    <= '0;
      r_p_ranks    <= '0;
      r_p_suits    <= '0;
      r_d_ranks    <= '0;
      r_d_suits    <= '0;
    end else begin
      r_lfsr       <= {r_lfsr[14:0], w_fb};
      r_new_game_q <= new_game;
      r_hit_q      <= hit;
      r_stand_q    <= stand;
      r_armed      <= 1'b1;

      if (w_take_p) begin
        r_p_hard  <= w_p_hard_nxt;
        r_p_ace   <= w_p_ace_nxt;
        r_p_count <= w_p_count_inc;
        for (int i = 0; i < MAX_CARDS; i++) begin
          if (r_p_count == CW'(i)) begin
            r_p_ranks[4*i +: 4] <= w_rank;
            r_p_suits[2*i +: 2] <= w_suit;
          end
        end
      end

      if (w_take_d) begin
        r_d_hard  <= w_d_hard_nxt;
        r_d_ace   <= w_d_ace_nxt;
        r_d_count <= w_d_count_inc;
        for (int i = 0; i < MAX_CARDS; i++) begin
          if (r_d_count == CW'(i)) begin
            r_d_ranks[4*i +: 4] <= w_rank;
            r_d_suits[2*i +: 2] <= w_suit;
          end
        end
      end

      case (r_state)
        S_DEAL: begin
          r_k <= r_k + 2'd1;
          if (r_k == 2'd3) begin
            r_state <= (w_p_score == c_bj) ? S_DEALER : S_PLAYER;
          end
        end
        S_PLAYER: begin
          if (w_stand_rise) begin
            r_state <= S_DEALER;
          end else if (w_hit_rise) begin
            if (w_p_score_nxt > c_bj) begin
              r_state   <= S_RESULT;
              r_outcome <= 2'd2;
            end else if (w_p_count_inc == c_max) begin
              r_state <= S_DEALER;
            end
          end
        end
        S_DEALER: begin
          if (!w_d_draw) begin
            r_state   <= S_RESULT;
            r_outcome <= judge(w_p_score, w_d_score);
          end
        end
        default: ;
      endcase

      // A new game wipes both hands and the outcome on the edge that enters DEAL.
      if (w_start) begin
        r_state   <= S_DEAL;
        r_k       <= 2'd0;
        r_outcome <= 2'd0;
        r_p_hard  <= 6'd0;
        r_d_hard  <= 6'd0;
        r_p_ace   <= 1'b0;
        r_d_ace   <= 1'b0;
        r_p_count <= '0;
        r_d_count <= '0;
        r_p_ranks <= '0;
        r_p_suits <= '0;
        r_d_ranks <= '0;
        r_d_suits <= '0;
      end
    end
  end

  assign card_take     = w_take_p | w_take_d;
  assign player_ranks  = r_p_ranks;
  assign player_suits  = r_p_suits;
  assign dealer_ranks  = r_d_ranks;
  assign dealer_suits  = r_d_suits;
  assign player_count  = r_p_count;
  assign dealer_count  = r_d_count;
  assign player_score  = w_p_score;
  assign dealer_score  = w_d_score;
  assign dealer_hidden = (r_state == S_DEAL) || (r_state == S_PLAYER);
  assign phase         = r_state;
  assign outcome       = r_outcome;

endmodule
`default_nettype wire

// File: doc/blackjack_game_ctrl.md
# blackjack_game_ctrl

Parametrised blackjack game engine that replaces the fixed-hand demo FSM. It deals from an internal LFSR shoe or an external card source, tracks player and dealer hands of up to `MAX_CARDS` cards, and computes ace-aware scores. It plays the dealer automatically and reports the outcome. Its hand outputs feed the per-card renderer chain in the VGA pipeline; it contains no pixel logic.

## Interface
Parameters:
- `MAX_CARDS`, default 9: card slots per hand, legal range 4..15.
- `DEALER_STAND`, default 17: dealer stops drawing at score ≥ this value.
- `EXT_DECK`, default 0: 0 = internal LFSR deck; 1 = cards come from the `ext_rank`/`ext_suit` ports.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

Ports (`CW` = $clog2(MAX_CARDS+1)):
- `clk` in 1: clock, posedge active.
- `rst` in 1: reset, synchronous, active-high.
- `new_game` in 1: level button (left mouse); acts on its rising edge.
- `hit` in 1: level button; acts on its rising edge.
- `stand` in 1: level button (right mouse); acts on its rising edge.
- `ext_rank` in 4: external card rank 1..13; used only when `EXT_DECK`=1.
- `ext_suit` in 2: external card suit; used only when `EXT_DECK`=1.
- `card_take` out 1: high in each cycle a card is consumed from the deck.
- `player_ranks` out 4*MAX_CARDS: slot i occupies [4i+3:4i]; 0 = empty slot.
- `player_suits` out 2*MAX_CARDS: slot i occupies [2i+1:2i].
- `dealer_ranks` out 4*MAX_CARDS: same layout as `player_ranks`.
- `dealer_suits` out 2*MAX_CARDS: same layout as `player_suits`.
- `player_count` out CW: player cards held.
- `dealer_count` out CW: dealer cards held.
- `player_score` out 6: player best score.
- `dealer_score` out 6: dealer best score.
- `dealer_hidden` out 1: renderer masks dealer slot 1 when high.
- `phase` out 3: current state encoding.
- `outcome` out 2: 0 none, 1 player wins, 2 dealer wins, 3 push.

## Operation
- Edge detect: `x_q <= x` each cycle; `x_rise = x & ~x_q`. Holding a button produces exactly one action.
- Deck, internal: 16-bit Fibonacci LFSR with taps 16,14,13,11, advanced every cycle including IDLE.
  - `r = lfsr[3:0]`; rank = (r ≥ 13 ? r-13 : r) + 1.
  - suit = `lfsr[5:4]`.
  - Infinite shoe; there is no depletion tracking.
- Deck, external: a card is sampled from `ext_rank`/`ext_suit` in each `card_take` cycle.
- Card point values: rank 1 = 1 point; ranks 11..13 = 10 points; other ranks = face value.
- Per hand, the block keeps `hard` (6-bit sum of points) and `ace` (hand holds at least one ace).
  - Score = hard + 10 if `ace` and hard ≤ 11; otherwise score = hard.
- States:
  - IDLE: hands cleared. `new_game_rise` → DEAL.
  - DEAL: 2-bit counter `k`. One card per cycle, in the order P, D, P, D. After k=3:
    - player_score = 21 → DEALER_TURN;
    - otherwise → PLAYER_TURN.
  - PLAYER_TURN: `stand_rise` → DEALER_TURN. Stand has priority if `stand_rise` and `hit_rise` occur in the same cycle.
    - Else `hit_rise` → deal one player card.
    - If the new score > 21 → RESULT.
    - Else if player_count reaches MAX_CARDS → DEALER_TURN.
  - DEALER_TURN: one dealer card per cycle while dealer_score < DEALER_STAND and dealer_count < MAX_CARDS; otherwise → RESULT.
  - RESULT: `outcome` is latched on entry:
    - player > 21 → 2;
    - else dealer > 21 → 1;
    - else compare scores → 1, 2 or 3.
    - Outcome holds until `new_game_rise` → DEAL.
- `new_game_rise` outside IDLE and RESULT is ignored. `hit` and `stand` are ignored outside PLAYER_TURN.
- `dealer_hidden` = 1 in DEAL and PLAYER_TURN; 0 in all other states.
- Entering DEAL clears all slots, counts, `hard`/`ace` registers and `outcome` in the same edge.

## Timing
- Reset: every output is 0, state IDLE, LFSR = SEED, all `x_q` registers = 0. `rst` overrides all other inputs in the same cycle.
- Reset mid-game returns to IDLE on the next edge with hands cleared.
- Button latency: the rising edge sampled at edge n produces its state/hand change at edge n. Outputs are visible after edge n.
- A card's slot, count and score all update on the same edge. `card_take` is high in the preceding cycle, which is the cycle the card is sampled.
- DEAL lasts exactly 4 cycles, with `card_take` high in all 4.
- The dealer draws 1 card/cycle. RESULT is entered one cycle after the dealer's stop condition becomes true.
- Counts saturate at MAX_CARDS. No slot writes occur beyond index MAX_CARDS-1.

## Test plan
- Reset with all inputs held high → all outputs 0, phase IDLE. Held `new_game` after `rst` falls → no deal until it drops and rises again.
- EXT_DECK=1, deal P10, D9, P1, D7 → player 21 with automatic stand. Dealer 16 draws 5 → dealer 21 → outcome 3, dealer_count 3.
- EXT_DECK=1, P10, D10, P6, D7, then hit with rank 12 → player 26 → RESULT, outcome 2, dealer_count 2, dealer_hidden 0.
- EXT_DECK=1, P1, D10, P5, D6: player soft 16. Hit 10 → player hard 16; stand. Dealer draws 10 → 26 → outcome 1.
- MAX_CARDS=4, P2, D10, P2, D8: hit 2 twice → player_count 4 → forced DEALER_TURN. Further `hit` presses ignored; dealer stands at 18 → outcome 2.
- EXT_DECK=0, default SEED → 4 consecutive `card_take` pulses in DEAL. Every dealt rank is in 1..13. Identical sequence on a second run from reset with the same press timing.
